// File: rtl/control_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, FSM states, op classes,
// ALU op selects and the packed control-strobe word.
package control_pkg;

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpLdi  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpShr  = 5'b00101;
    localparam logic [4:0] OpShl  = 5'b00110;
    localparam logic [4:0] OpRor  = 5'b00111;
    localparam logic [4:0] OpRol  = 5'b01000;
    localparam logic [4:0] OpAnd  = 5'b01001;
    localparam logic [4:0] OpOr   = 5'b01010;
    localparam logic [4:0] OpAddi = 5'b01011;
    localparam logic [4:0] OpAndi = 5'b01100;
    localparam logic [4:0] OpOri  = 5'b01101;
    localparam logic [4:0] OpMul  = 5'b01110;
    localparam logic [4:0] OpDiv  = 5'b01111;
    localparam logic [4:0] OpNeg  = 5'b10000;
    localparam logic [4:0] OpNot  = 5'b10001;
    localparam logic [4:0] OpBr   = 5'b10010;
    localparam logic [4:0] OpJr   = 5'b10011;
    localparam logic [4:0] OpIn   = 5'b10101;
    localparam logic [4:0] OpOut  = 5'b10110;
    localparam logic [4:0] OpNop  = 5'b11001;
    localparam logic [4:0] OpHalt = 5'b11010;

    // ld/ldi/st share their first two execute steps (StMemT3/StMemT4)
    typedef enum logic [4:0] {
        StRst, StT0, StT1, StT2,
        StAluT3, StAluT4, StAluT5,
        StImmT3, StImmT4, StImmT5,
        StNegT3, StNegT4,
        StMdT3, StMdT4, StMdT5,
        StMemT3, StMemT4, StLdT5, StLdT6, StLdT7, StLdiT5, StStT5, StStT6,
        StBrT3, StBrT4, StBrT5,
        StJrT3, StInT3, StOutT3,
        StHalt
    } state_e;

    typedef enum logic [3:0] {
        ClsNop, ClsAlu, ClsImm, ClsNeg, ClsMd, ClsLd, ClsLdi, ClsSt,
        ClsBr, ClsJr, ClsIn, ClsOut, ClsHalt
    } op_class_e;

    // Order matches the MSB-first layout of ctrl_t.alu (ADD ... IncPC)
    typedef enum logic [3:0] {
        AluNone, AluAdd, AluSub, AluMul, AluDiv, AluShr, AluShl, AluRor, AluRol,
        AluAnd, AluOr, AluNeg, AluNot, AluInc
    } alu_op_e;

    typedef struct packed {
        logic pc_in, ir_in, ry_in, rz_in, mar_in, hilo_in, mdr_in, output_in;
        logic read, write;
        logic input_out, mdr_out, hilo_out, rz_out, pc_out, c_out;
        logic ba_out, gra, grb, grc, r_out, r_in;
        logic [12:0] alu;
    } ctrl_t;

    function automatic logic [12:0] alu_onehot(alu_op_e op);
        if (op == AluNone) return 13'd0;
        return 13'h1000 >> (4'(op) - 4'd1);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface control_sequencer_if #(
    parameter int unsigned BITS = 32
);
    logic [BITS-1:0] IRVal;
    logic CON, Stop, Run;
    logic [4:0] state_out;
    logic PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, OUTPUTin;
    logic Read, Write;
    logic INPUTout, MDRout, HILOout, RZout, PCout, Cout;
    logic BAout, Gra, Grb, Grc, Rout, Rin;
    logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC;

    modport master (
        input  IRVal, CON, Stop,
        output Run, state_out,
        output PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, OUTPUTin, Read, Write,
        output INPUTout, MDRout, HILOout, RZout, PCout, Cout,
        output BAout, Gra, Grb, Grc, Rout, Rin,
        output ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC
    );

    modport slave (
        output IRVal, CON, Stop,
        input  Run, state_out,
        input  PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, OUTPUTin, Read, Write,
        input  INPUTout, MDRout, HILOout, RZout, PCout, Cout,
        input  BAout, Gra, Grb, Grc, Rout, Rin,
        input  ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC
    );
endinterface

// File: rtl/control_sequencer_op_decoder.sv
// Combinational opcode decode into an execute class and the ALU op it uses.
module op_decoder
    import control_pkg::*;
(
    input  logic [4:0] opcode_i,
    output op_class_e  op_class_o,
    output alu_op_e    alu_op_o
);
    always_comb begin
        op_class_o = ClsNop;
        alu_op_o   = AluNone;
        case (opcode_i)
            OpLd:   begin op_class_o = ClsLd;  alu_op_o = AluAdd; end
            OpLdi:  begin op_class_o = ClsLdi; alu_op_o = AluAdd; end
            OpSt:   begin op_class_o = ClsSt;  alu_op_o = AluAdd; end
            OpAdd:  begin op_class_o = ClsAlu; alu_op_o = AluAdd; end
            OpSub:  begin op_class_o = ClsAlu; alu_op_o = AluSub; end
            OpShr:  begin op_class_o = ClsAlu; alu_op_o = AluShr; end
            OpShl:  begin op_class_o = ClsAlu; alu_op_o = AluShl; end
            OpRor:  begin op_class_o = ClsAlu; alu_op_o = AluRor; end
            OpRol:  begin op_class_o = ClsAlu; alu_op_o = AluRol; end
            OpAnd:  begin op_class_o = ClsAlu; alu_op_o = AluAnd; end
            OpOr:   begin op_class_o = ClsAlu; alu_op_o = AluOr;  end
            OpAddi: begin op_class_o = ClsImm; alu_op_o = AluAdd; end
            OpAndi: begin op_class_o = ClsImm; alu_op_o = AluAnd; end
            OpOri:  begin op_class_o = ClsImm; alu_op_o = AluOr;  end
            OpMul:  begin op_class_o = ClsMd;  alu_op_o = AluMul; end
            OpDiv:  begin op_class_o = ClsMd;  alu_op_o = AluDiv; end
            OpNeg:  begin op_class_o = ClsNeg; alu_op_o = AluNeg; end
            OpNot:  begin op_class_o = ClsNeg; alu_op_o = AluNot; end
            OpBr:   begin op_class_o = ClsBr;  alu_op_o = AluAdd; end
            OpJr:   op_class_o = ClsJr;
            OpIn:   op_class_o = ClsIn;
            OpOut:  op_class_o = ClsOut;
            OpHalt: op_class_o = ClsHalt;
            default: op_class_o = ClsNop;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore sequencer: fetch T0-T2, per-class execute steps, HALT.
// Strobes are registered alongside the state they belong to.
module control_sequencer
    import control_pkg::*;
#(
    parameter int unsigned BITS = 32,
    parameter int unsigned OPW  = 5
) (
    input logic                clk,
    input logic                reset,
    control_sequencer_if.master bus
);
    state_e    state_q, state_d;
    op_class_e cls_q, cls_d, dec_class;
    alu_op_e   op_q, op_d, dec_op;
    ctrl_t     ctrl_q, ctrl_d;
    logic      run_q, run_d, done;
    logic [OPW-1:0] opcode;

    assign opcode = bus.IRVal[BITS-1 -: OPW];

    op_decoder u_op_decoder (
        .opcode_i   (opcode),
        .op_class_o (dec_class),
        .alu_op_o   (dec_op)
    );

    function automatic ctrl_t ctrl_for(state_e s, alu_op_e op, logic con);
        ctrl_t c = '0;
        case (s)
            StT0:    begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.alu = alu_onehot(AluInc);
                           c.rz_in = 1'b1; end
            StT1:    begin c.rz_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
            StT2:    begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
            StAluT3, StImmT3: begin c.grb = 1'b1; c.r_out = 1'b1; c.ry_in = 1'b1; end
            StAluT4: begin c.grc = 1'b1; c.r_out = 1'b1; c.alu = alu_onehot(op);
                           c.rz_in = 1'b1; end
            StImmT4, StMemT4, StBrT4: begin c.c_out = 1'b1; c.alu = alu_onehot(op);
                           c.rz_in = 1'b1; end
            StAluT5, StImmT5, StNegT4, StLdiT5: begin c.rz_out = 1'b1; c.gra = 1'b1;
                           c.r_in = 1'b1; end
            StNegT3, StMdT4: begin c.grb = 1'b1; c.r_out = 1'b1; c.alu = alu_onehot(op);
                           c.rz_in = 1'b1; end
            StMdT3:  begin c.gra = 1'b1; c.r_out = 1'b1; c.ry_in = 1'b1; end
            StMdT5:  begin c.rz_out = 1'b1; c.hilo_in = 1'b1; end
            StMemT3: begin c.grb = 1'b1; c.ba_out = 1'b1; c.ry_in = 1'b1; end
            StLdT5, StStT5: begin c.rz_out = 1'b1; c.mar_in = 1'b1; end
            StLdT6:  begin c.read = 1'b1; c.mdr_in = 1'b1; end
            StLdT7:  begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            StStT6:  begin c.gra = 1'b1; c.r_out = 1'b1; c.write = 1'b1; end
            StBrT3:  begin c.pc_out = 1'b1; c.ry_in = 1'b1; end
            StBrT5:  begin c.rz_out = con; c.pc_in = con; end
            StJrT3:  begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
            StInT3:  begin c.input_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            StOutT3: begin c.gra = 1'b1; c.r_out = 1'b1; c.output_in = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        op_d    = op_q;
        done    = 1'b0;
        case (state_q)
            StRst:   state_d = StT0;
            StT0:    state_d = StT1;
            StT1:    state_d = StT2;
            StT2: begin
                cls_d = dec_class;
                op_d  = dec_op;
                case (dec_class)
                    ClsAlu:                state_d = StAluT3;
                    ClsImm:                state_d = StImmT3;
                    ClsNeg:                state_d = StNegT3;
                    ClsMd:                 state_d = StMdT3;
                    ClsLd, ClsLdi, ClsSt:  state_d = StMemT3;
                    ClsBr:                 state_d = StBrT3;
                    ClsJr:                 state_d = StJrT3;
                    ClsIn:                 state_d = StInT3;
                    ClsOut:                state_d = StOutT3;
                    ClsHalt:               state_d = StHalt;
                    default:               done    = 1'b1;
                endcase
            end
            StAluT3: state_d = StAluT4;
            StAluT4: state_d = StAluT5;
            StImmT3: state_d = StImmT4;
            StImmT4: state_d = StImmT5;
            StNegT3: state_d = StNegT4;
            StMdT3:  state_d = StMdT4;
            StMdT4:  state_d = StMdT5;
            StMemT3: state_d = StMemT4;
            StMemT4: state_d = (cls_q == ClsLd) ? StLdT5 : (cls_q == ClsSt) ? StStT5 : StLdiT5;
            StLdT5:  state_d = StLdT6;
            StLdT6:  state_d = StLdT7;
            StStT5:  state_d = StStT6;
            StBrT3:  state_d = StBrT4;
            StBrT4:  state_d = StBrT5;
            StAluT5, StImmT5, StNegT4, StMdT5, StLdT7, StLdiT5, StStT6, StBrT5,
            StJrT3, StInT3, StOutT3: done = 1'b1;
            StHalt:  state_d = StHalt;
            default: state_d = StRst;
        endcase
        // Stop is only honoured on an instruction boundary
        if (done) state_d = bus.Stop ? StHalt : StT0;
        ctrl_d = ctrl_for(state_d, op_d, bus.CON);
        run_d  = (state_d != StHalt);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StRst;
            cls_q   <= ClsNop;
            op_q    <= AluNone;
            ctrl_q  <= '0;
            run_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
            run_q   <= run_d;
        end
    end

    assign bus.Run       = run_q;
    assign bus.state_out = state_q;
    assign {bus.PCin, bus.IRin, bus.RYin, bus.RZin, bus.MARin, bus.HILOin, bus.MDRin,
            bus.OUTPUTin, bus.Read, bus.Write, bus.INPUTout, bus.MDRout, bus.HILOout,
            bus.RZout, bus.PCout, bus.Cout, bus.BAout, bus.Gra, bus.Grb, bus.Grc, bus.Rout,
            bus.Rin, bus.ADD, bus.SUB, bus.MUL, bus.DIV, bus.SHR, bus.SHL, bus.ROR, bus.ROL,
            bus.AND, bus.OR, bus.NEGATE, bus.NOT, bus.IncPC} = ctrl_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for the control sequencer.
module tb_control_sequencer;
    localparam int unsigned BITS = 32;

    localparam logic [35:0] M_RUN = 36'd1 << 35, M_PCIN = 36'd1 << 34, M_IRIN = 36'd1 << 33;
    localparam logic [35:0] M_RYIN = 36'd1 << 32, M_RZIN = 36'd1 << 31, M_MARIN = 36'd1 << 30;
    localparam logic [35:0] M_HILOIN = 36'd1 << 29, M_MDRIN = 36'd1 << 28;
    localparam logic [35:0] M_OUTIN = 36'd1 << 27, M_RD = 36'd1 << 26, M_WR = 36'd1 << 25;
    localparam logic [35:0] M_INOUT = 36'd1 << 24, M_MDROUT = 36'd1 << 23;
    localparam logic [35:0] M_RZOUT = 36'd1 << 21, M_PCOUT = 36'd1 << 20, M_COUT = 36'd1 << 19;
    localparam logic [35:0] M_BAOUT = 36'd1 << 18, M_GRA = 36'd1 << 17, M_GRB = 36'd1 << 16;
    localparam logic [35:0] M_GRC = 36'd1 << 15, M_ROUT = 36'd1 << 14, M_RIN = 36'd1 << 13;
    localparam logic [35:0] M_ADD = 36'd1 << 12, M_MUL = 36'd1 << 10, M_OR = 36'd1 << 3;
    localparam logic [35:0] M_NEG = 36'd1 << 2, M_INC = 36'd1 << 0;

    localparam logic [35:0] T0E = M_RUN | M_PCOUT | M_MARIN | M_INC | M_RZIN;
    localparam logic [35:0] T1E = M_RUN | M_RZOUT | M_PCIN | M_RD | M_MDRIN;
    localparam logic [35:0] T2E = M_RUN | M_MDROUT | M_IRIN;

    logic clk = 1'b0;
    logic reset;
    logic [35:0] obs;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        con;
        logic        stop;
        logic [35:0] exp;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    control_sequencer_if #(.BITS(BITS)) bus ();

    control_sequencer #(.BITS(BITS), .OPW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign obs = {bus.Run, bus.PCin, bus.IRin, bus.RYin, bus.RZin, bus.MARin, bus.HILOin,
                  bus.MDRin, bus.OUTPUTin, bus.Read, bus.Write, bus.INPUTout, bus.MDRout,
                  bus.HILOout, bus.RZout, bus.PCout, bus.Cout, bus.BAout, bus.Gra, bus.Grb,
                  bus.Grc, bus.Rout, bus.Rin, bus.ADD, bus.SUB, bus.MUL, bus.DIV, bus.SHR,
                  bus.SHL, bus.ROR, bus.ROL, bus.AND, bus.OR, bus.NEGATE, bus.NOT, bus.IncPC};

    task automatic check(input string name, input logic [35:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input logic [31:0] ir, input logic con,
                        input logic stop, input logic [35:0] exp);
        vec_t v;
        v.name = nm;
        v.ir   = ir;
        v.con  = con;
        v.stop = stop;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    task automatic fetch(input string nm, input logic [31:0] ir, input logic con);
        push({nm, "_T1"}, ir, con, 1'b0, T1E);
        push({nm, "_T2"}, ir, con, 1'b0, T2E);
    endtask

    initial begin
        // add r1,r2,r3
        fetch("add", 32'h18918000, 1'b0);
        push("add_T3", 32'h18918000, 1'b0, 1'b0, M_RUN | M_GRB | M_ROUT | M_RYIN);
        push("add_T4", 32'h18918000, 1'b0, 1'b0, M_RUN | M_GRC | M_ROUT | M_ADD | M_RZIN);
        push("add_T5", 32'h18918000, 1'b0, 1'b0, M_RUN | M_RZOUT | M_GRA | M_RIN);
        push("add_T0", 32'h18918000, 1'b0, 1'b0, T0E);
        // ld r1,0x20(r2)
        fetch("ld", 32'h00900020, 1'b0);
        push("ld_T3", 32'h00900020, 1'b0, 1'b0, M_RUN | M_GRB | M_BAOUT | M_RYIN);
        push("ld_T4", 32'h00900020, 1'b0, 1'b0, M_RUN | M_COUT | M_ADD | M_RZIN);
        push("ld_T5", 32'h00900020, 1'b0, 1'b0, M_RUN | M_RZOUT | M_MARIN);
        push("ld_T6", 32'h00900020, 1'b0, 1'b0, M_RUN | M_RD | M_MDRIN);
        push("ld_T7", 32'h00900020, 1'b0, 1'b0, M_RUN | M_MDROUT | M_GRA | M_RIN);
        push("ld_T0", 32'h00900020, 1'b0, 1'b0, T0E);
        // br, not taken then taken
        for (int c = 0; c < 2; c++) begin
            fetch("br", 32'h90000000, c[0]);
            push("br_T3", 32'h90000000, c[0], 1'b0, M_RUN | M_PCOUT | M_RYIN);
            push("br_T4", 32'h90000000, c[0], 1'b0, M_RUN | M_COUT | M_ADD | M_RZIN);
            push("br_T5", 32'h90000000, c[0], 1'b0,
                 c[0] ? (M_RUN | M_RZOUT | M_PCIN) : M_RUN);
            push("br_T0", 32'h90000000, c[0], 1'b0, T0E);
        end
        // or
        fetch("or", 32'h50000000, 1'b0);
        push("or_T3", 32'h50000000, 1'b0, 1'b0, M_RUN | M_GRB | M_ROUT | M_RYIN);
        push("or_T4", 32'h50000000, 1'b0, 1'b0, M_RUN | M_GRC | M_ROUT | M_OR | M_RZIN);
        push("or_T5", 32'h50000000, 1'b0, 1'b0, M_RUN | M_RZOUT | M_GRA | M_RIN);
        push("or_T0", 32'h50000000, 1'b0, 1'b0, T0E);
        // neg
        fetch("neg", 32'h80000000, 1'b0);
        push("neg_T3", 32'h80000000, 1'b0, 1'b0, M_RUN | M_GRB | M_ROUT | M_NEG | M_RZIN);
        push("neg_T4", 32'h80000000, 1'b0, 1'b0, M_RUN | M_RZOUT | M_GRA | M_RIN);
        push("neg_T0", 32'h80000000, 1'b0, 1'b0, T0E);
        // addi
        fetch("addi", 32'h58000000, 1'b0);
        push("addi_T3", 32'h58000000, 1'b0, 1'b0, M_RUN | M_GRB | M_ROUT | M_RYIN);
        push("addi_T4", 32'h58000000, 1'b0, 1'b0, M_RUN | M_COUT | M_ADD | M_RZIN);
        push("addi_T5", 32'h58000000, 1'b0, 1'b0, M_RUN | M_RZOUT | M_GRA | M_RIN);
        push("addi_T0", 32'h58000000, 1'b0, 1'b0, T0E);
        // st
        fetch("st", 32'h10000000, 1'b0);
        push("st_T3", 32'h10000000, 1'b0, 1'b0, M_RUN | M_GRB | M_BAOUT | M_RYIN);
        push("st_T4", 32'h10000000, 1'b0, 1'b0, M_RUN | M_COUT | M_ADD | M_RZIN);
        push("st_T5", 32'h10000000, 1'b0, 1'b0, M_RUN | M_RZOUT | M_MARIN);
        push("st_T6", 32'h10000000, 1'b0, 1'b0, M_RUN | M_GRA | M_ROUT | M_WR);
        push("st_T0", 32'h10000000, 1'b0, 1'b0, T0E);
        // jr, in, out
        fetch("jr", 32'h98000000, 1'b0);
        push("jr_T3", 32'h98000000, 1'b0, 1'b0, M_RUN | M_GRA | M_ROUT | M_PCIN);
        push("jr_T0", 32'h98000000, 1'b0, 1'b0, T0E);
        fetch("in", 32'hA8000000, 1'b0);
        push("in_T3", 32'hA8000000, 1'b0, 1'b0, M_RUN | M_INOUT | M_GRA | M_RIN);
        push("in_T0", 32'hA8000000, 1'b0, 1'b0, T0E);
        fetch("out", 32'hB0000000, 1'b0);
        push("out_T3", 32'hB0000000, 1'b0, 1'b0, M_RUN | M_GRA | M_ROUT | M_OUTIN);
        push("out_T0", 32'hB0000000, 1'b0, 1'b0, T0E);
        // undefined opcode 11111 behaves as nop
        fetch("undef", 32'hF8000000, 1'b0);
        push("undef_T0", 32'hF8000000, 1'b0, 1'b0, T0E);
        // mul with Stop raised during T4: T5 still runs, then HALT
        fetch("mul", 32'h70000000, 1'b0);
        push("mul_T3", 32'h70000000, 1'b0, 1'b0, M_RUN | M_GRA | M_ROUT | M_RYIN);
        push("mul_T4", 32'h70000000, 1'b0, 1'b0, M_RUN | M_GRB | M_ROUT | M_MUL | M_RZIN);
        push("mul_T5", 32'h70000000, 1'b0, 1'b1, M_RUN | M_RZOUT | M_HILOIN);
        push("mul_halt", 32'h70000000, 1'b0, 1'b1, 36'd0);
        push("mul_halt2", 32'h70000000, 1'b0, 1'b0, 36'd0);

        reset     = 1'b0;
        bus.IRVal = 32'h18918000;
        bus.CON   = 1'b0;
        bus.Stop  = 1'b0;
        step();
        check("rst_c1", M_RUN);
        step();
        check("rst_c2", M_RUN);
        reset = 1'b1;
        step();
        check("first_T0", T0E);

        foreach (vecs[i]) begin
            bus.IRVal = vecs[i].ir;
            bus.CON   = vecs[i].con;
            bus.Stop  = vecs[i].stop;
            step();
            check(vecs[i].name, vecs[i].exp);
        end

        // Reset leaves HALT, then halt opcode parks the sequencer
        reset = 1'b0;
        step();
        check("halt_rst", M_RUN);
        reset     = 1'b1;
        bus.IRVal = 32'hD0000000;
        step();
        check("halt_T0", T0E);
        step();
        check("halt_T1", T1E);
        step();
        check("halt_T2", T2E);
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("halt_hold%0d", k), 36'd0);
        end
        reset = 1'b0;
        step();
        check("halt_rst2", M_RUN);
        reset = 1'b1;
        step();
        check("restart_T0", T0E);

        // Reset in the middle of ld aborts cleanly
        bus.IRVal = 32'h00900020;
        step();
        check("abort_T1", T1E);
        step();
        check("abort_T2", T2E);
        step();
        check("abort_T3", M_RUN | M_GRB | M_BAOUT | M_RYIN);
        step();
        check("abort_T4", M_RUN | M_COUT | M_ADD | M_RZIN);
        reset = 1'b0;
        step();
        check("abort_rst", M_RUN);
        reset = 1'b1;
        step();
        check("abort_T0", T0E);
        step();
        check("abort_next_T1", T1E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
